// File: rtl/dmi_uncore_pkg.sv
// rtl/dmi_uncore_pkg.sv - register addresses and STATUS bit positions for the uncore mailbox
package dmi_uncore_pkg;

    localparam logic [6:0] ADDR_STATUS   = 7'h50;
    localparam logic [6:0] ADDR_DOWN     = 7'h51;
    localparam logic [6:0] ADDR_UP       = 7'h52;
    localparam logic [6:0] ADDR_SCRATCH  = 7'h53;
    localparam logic [6:0] ADDR_ID       = 7'h54;
    localparam logic [6:0] ADDR_IRQ_MASK = 7'h55;

    localparam int ST_DOWN_CNT_LSB = 0;
    localparam int ST_UP_CNT_LSB   = 8;
    localparam int ST_DOWN_FULL    = 16;
    localparam int ST_UP_EMPTY     = 17;
    localparam int ST_UNDERFLOW    = 30;
    localparam int ST_OVERFLOW     = 31;

endpackage

// File: rtl/dmi_mbox_fifo.sv
// rtl/dmi_mbox_fifo.sv - power-of-two FIFO with occupancy count; push when full and pop when empty are ignored
module dmi_mbox_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_ptr_q];
    // Both gates use the pre-edge state, so a full FIFO refuses a push even if it pops this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dmi_uncore_mbox.sv
// rtl/dmi_uncore_mbox.sv - DMI uncore responder: ID/scratch/status registers and a two-way mailbox
// Optional interrupt output and IRQ_MASK register under DMI_UNCORE_MBOX_IRQ_EN.
module dmi_uncore_mbox
    import dmi_uncore_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] ID_VALUE = 32'h0000_0E12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmi_uncore_en,
    input  logic        dmi_uncore_wr_en,
    input  logic [6:0]  dmi_uncore_addr,
    input  logic [31:0] dmi_uncore_wdata,
    output logic [31:0] dmi_uncore_rdata,
    output logic        down_valid,
    output logic [31:0] down_data,
    input  logic        down_ready,
    input  logic        up_valid,
    input  logic [31:0] up_data,
    output logic        up_ready
`ifdef DMI_UNCORE_MBOX_IRQ_EN
    ,
    output logic        mbox_irq
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0] rdata_q, rdata_d;
    logic [31:0] scratch_q, scratch_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;
    logic        wr_acc, rd_acc;
    logic        down_push, down_full, down_empty;
    logic        up_push, up_pop, up_full, up_empty;
    logic [CW-1:0] down_count, up_count;
    logic [31:0] up_head;
    logic [31:0] status;

    assign wr_acc     = dmi_uncore_en & dmi_uncore_wr_en;
    assign rd_acc     = dmi_uncore_en & ~dmi_uncore_wr_en;
    assign down_push  = wr_acc & (dmi_uncore_addr == ADDR_DOWN);
    assign up_pop     = rd_acc & (dmi_uncore_addr == ADDR_UP);
    assign up_push    = up_valid & up_ready;
    assign down_valid = ~down_empty;
    assign up_ready   = ~up_full;

    dmi_mbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_down_fifo (
        .clk(clk), .rst(rst),
        .push(down_push), .push_data(dmi_uncore_wdata),
        .pop(down_valid & down_ready),
        .head(down_data), .full(down_full), .empty(down_empty), .count(down_count)
    );

    dmi_mbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_up_fifo (
        .clk(clk), .rst(rst),
        .push(up_push), .push_data(up_data),
        .pop(up_pop),
        .head(up_head), .full(up_full), .empty(up_empty), .count(up_count)
    );

`ifdef DMI_UNCORE_MBOX_IRQ_EN
    logic [2:0] irq_mask_q, irq_mask_d;
    logic       irq_q, irq_d;

    assign mbox_irq = irq_q;

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_acc && dmi_uncore_addr == ADDR_IRQ_MASK) begin
            irq_mask_d = dmi_uncore_wdata[2:0];
        end
        irq_d = |(irq_mask_q & {udf_q, ovf_q, ~up_empty});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end
`endif

    always_comb begin
        status = '0;
        status[ST_DOWN_CNT_LSB +: 8] = 8'(down_count);
        status[ST_UP_CNT_LSB +: 8]   = 8'(up_count);
        status[ST_DOWN_FULL]         = down_full;
        status[ST_UP_EMPTY]          = up_empty;
        status[ST_UNDERFLOW]         = udf_q;
        status[ST_OVERFLOW]          = ovf_q;
    end

    always_comb begin
        scratch_d = scratch_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        rdata_d   = rdata_q;

        if (wr_acc && dmi_uncore_addr == ADDR_SCRATCH) begin
            scratch_d = dmi_uncore_wdata;
        end
        // Clear first, then set, so a same-cycle event keeps the flag up.
        if (wr_acc && dmi_uncore_addr == ADDR_STATUS) begin
            if (dmi_uncore_wdata[ST_OVERFLOW])  ovf_d = 1'b0;
            if (dmi_uncore_wdata[ST_UNDERFLOW]) udf_d = 1'b0;
        end
        if (down_push && down_full) ovf_d = 1'b1;
        if (up_pop && up_empty)     udf_d = 1'b1;

        if (rd_acc) begin
            case (dmi_uncore_addr)
                ADDR_STATUS:   rdata_d = status;
                ADDR_UP:       rdata_d = up_empty ? 32'h0 : up_head;
                ADDR_SCRATCH:  rdata_d = scratch_q;
                ADDR_ID:       rdata_d = ID_VALUE;
`ifdef DMI_UNCORE_MBOX_IRQ_EN
                ADDR_IRQ_MASK: rdata_d = {29'h0, irq_mask_q};
`endif
                default:       rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q   <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign dmi_uncore_rdata = rdata_q;

endmodule

// File: tb/tb_dmi_uncore_mbox.sv
// tb/tb_dmi_uncore_mbox.sv - scoreboard bench for the uncore mailbox (default DEPTH=4)
module tb_dmi_uncore_mbox;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmi_en, dmi_wr;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [31:0] rdata;
    logic        down_valid;
    logic [31:0] down_data;
    logic        down_ready;
    logic        up_valid;
    logic [31:0] up_data;
    logic        up_ready;
`ifdef DMI_UNCORE_MBOX_IRQ_EN
    logic        mbox_irq;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_rd[$];
    logic [31:0] exp_down[$];
    logic        rd_pend = 1'b0;

    always #5 clk = ~clk;

    dmi_uncore_mbox dut (
        .clk(clk), .rst(rst),
        .dmi_uncore_en(dmi_en), .dmi_uncore_wr_en(dmi_wr),
        .dmi_uncore_addr(dmi_addr), .dmi_uncore_wdata(dmi_wdata),
        .dmi_uncore_rdata(rdata),
        .down_valid(down_valid), .down_data(down_data), .down_ready(down_ready),
        .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready)
`ifdef DMI_UNCORE_MBOX_IRQ_EN
        , .mbox_irq(mbox_irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares read data one cycle after each read strobe and every down-stream handshake.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) check("rdata_no_expectation", rdata, 32'hxxxx_xxxx);
            else check("rdata", rdata, exp_rd.pop_front());
        end
        rd_pend = dmi_en && !dmi_wr && !rst;
        if (down_valid && down_ready && !rst) begin
            if (exp_down.size() == 0) check("down_data_unexpected", down_data, 32'hxxxx_xxxx);
            else check("down_data", down_data, exp_down.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
        dmi_en = 1'b1; dmi_wr = 1'b1; dmi_addr = a; dmi_wdata = d;
        tick();
        dmi_en = 1'b0; dmi_wr = 1'b0;
    endtask

    task automatic dmi_read(input logic [6:0] a, input logic [31:0] exp);
        exp_rd.push_back(exp);
        dmi_en = 1'b1; dmi_wr = 1'b0; dmi_addr = a; dmi_wdata = 32'h0;
        tick();
        dmi_en = 1'b0;
    endtask

    task automatic drain_down(input string name);
        down_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!down_valid) break;
            tick();
        end
        check(name, {31'h0, down_valid}, 32'h0);
        down_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dmi_en = 1'b0; dmi_wr = 1'b0; dmi_addr = '0; dmi_wdata = '0;
        down_ready = 1'b0; up_valid = 1'b0; up_data = '0;
        repeat (3) tick();
        check("reset_rdata", rdata, 32'h0);
        check("reset_down_valid", {31'h0, down_valid}, 32'h0);
        check("reset_up_ready", {31'h0, up_ready}, 32'h1);
`ifdef DMI_UNCORE_MBOX_IRQ_EN
        check("reset_irq", {31'h0, mbox_irq}, 32'h0);
`endif
        rst = 1'b0;
        tick();

        dmi_read(7'h54, 32'h0000_0E12);
        dmi_read(7'h50, 32'h0002_0000);

        dmi_write(7'h53, 32'hDEAD_BEEF);
        dmi_read(7'h53, 32'hDEAD_BEEF);
        dmi_write(7'h60, 32'h1);
        dmi_read(7'h60, 32'h0);
        dmi_read(7'h53, 32'hDEAD_BEEF);
        dmi_read(7'h51, 32'h0);
`ifndef DMI_UNCORE_MBOX_IRQ_EN
        dmi_write(7'h55, 32'h7);
        dmi_read(7'h55, 32'h0);
`endif

        // Strobe with en low must not reach SCRATCH.
        dmi_en = 1'b0; dmi_wr = 1'b1; dmi_addr = 7'h53; dmi_wdata = 32'h1234_5678;
        tick();
        dmi_wr = 1'b0;
        dmi_read(7'h53, 32'hDEAD_BEEF);

        // Overfill the down FIFO, then drain it.
        for (int v = 1; v <= 5; v++) dmi_write(7'h51, 32'(v));
        dmi_read(7'h50, 32'h8003_0004);
        for (int v = 1; v <= 4; v++) exp_down.push_back(32'(v));
        drain_down("down_drained");
        dmi_write(7'h50, 32'h8000_0000);
        dmi_read(7'h50, 32'h0002_0000);

        // Up FIFO: two words, then an underflow read.
        up_valid = 1'b1; up_data = 32'hA; tick();
        up_data = 32'hB; tick();
        up_valid = 1'b0;
        dmi_write(7'h52, 32'h5);
        dmi_read(7'h52, 32'hA);
        dmi_read(7'h52, 32'hB);
        dmi_read(7'h52, 32'h0);
        dmi_read(7'h50, 32'h4002_0000);
        dmi_write(7'h50, 32'h4000_0000);
        dmi_read(7'h50, 32'h0002_0000);

        // Full down FIFO: write and SoC pop in the same cycle drop the write.
        for (int v = 10; v <= 13; v++) dmi_write(7'h51, 32'(v));
        for (int v = 10; v <= 13; v++) exp_down.push_back(32'(v));
        dmi_en = 1'b1; dmi_wr = 1'b1; dmi_addr = 7'h51; dmi_wdata = 32'h99; down_ready = 1'b1;
        tick();
        dmi_en = 1'b0; dmi_wr = 1'b0; down_ready = 1'b0;
        dmi_read(7'h50, 32'h8002_0003);
        drain_down("down_drained_after_drop");
        dmi_write(7'h50, 32'h8000_0000);

        // Up FIFO: push and pop in one cycle at count 2.
        up_valid = 1'b1; up_data = 32'hC; tick();
        up_data = 32'hD; tick();
        up_data = 32'hE;
        exp_rd.push_back(32'hC);
        dmi_en = 1'b1; dmi_wr = 1'b0; dmi_addr = 7'h52;
        tick();
        dmi_en = 1'b0; up_valid = 1'b0;
        dmi_read(7'h50, 32'h0000_0200);
        dmi_read(7'h52, 32'hD);
        dmi_read(7'h52, 32'hE);
        dmi_read(7'h50, 32'h0002_0000);

`ifdef DMI_UNCORE_MBOX_IRQ_EN
        dmi_write(7'h55, 32'h1);
        dmi_read(7'h55, 32'h1);
        up_valid = 1'b1; up_data = 32'h77; tick();
        up_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (mbox_irq) break;
            tick();
        end
        check("irq_set", {31'h0, mbox_irq}, 32'h1);
        dmi_read(7'h52, 32'h77);
        for (int i = 0; i < 3; i++) begin
            if (!mbox_irq) break;
            tick();
        end
        check("irq_clear", {31'h0, mbox_irq}, 32'h0);
`endif

        // Reset in the middle of traffic discards everything.
        dmi_write(7'h51, 32'h55);
        up_valid = 1'b1; up_data = 32'h66; tick();
        up_valid = 1'b0;
        dmi_read(7'h53, 32'hDEAD_BEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_rdata", rdata, 32'h0);
        check("midreset_down_valid", {31'h0, down_valid}, 32'h0);
        dmi_read(7'h50, 32'h0002_0000);
        dmi_read(7'h53, 32'h0);
        dmi_read(7'h52, 32'h0);

        repeat (3) tick();
        check("rd_queue_empty", 32'(exp_rd.size()), 32'h0);
        check("down_queue_empty", 32'(exp_down.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
